// File: rtl/dmem_access_ctrl_pkg.sv
// Shared constants for the MEM-stage data memory access controller.
package dmem_access_ctrl_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_RWAIT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Byte address -> word address: the two low bits are dropped
  localparam int WADDR_LSB = 2;

  // Empty byte-lane mask; also the mask presented on reads
  localparam logic [3:0] MASK_NONE = 4'b0000;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Timeout counter: cleared when a wait phase starts, counts while waiting,
// flags the last allowed cycle (count == TIMEOUT-1) and saturates there.
module dmem_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  // Values 0..TIMEOUT-1 only; TIMEOUT=1 still needs one bit
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] r_cnt;

  assign o_tc = (r_cnt == CW'(TIMEOUT - 1));

  // Clear wins over increment; hold at terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_cnt <= '0;
    else if (i_clr)         r_cnt <= '0;
    else if (i_inc && !o_tc) r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory access controller: latches one load/store from the
// pipeline, runs the req/ready/rvalid handshake, stalls until completion and
// aborts with a sticky error when the memory does not answer in time.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        MemRen,
  input  logic                        MemWEn,
  input  logic [ADDR_W-1:0]           MemAddress,
  input  logic [3:0]                  MemWriteMask,
  input  logic [31:0]                 DataToMem,
  output logic                        Stall,
  output logic [31:0]                 DataFromMem,
  output logic                        DataValid,
  output logic                        AccessErr,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-WADDR_LSB-1:0] mem_addr,
  output logic [3:0]                  mem_wmask,
  output logic [31:0]                 mem_wdata,
  input  logic                        mem_ready,
  input  logic                        mem_rvalid,
  input  logic [31:0]                 mem_rdata
);

  logic [1:0]                  r_state;
  logic                        r_we;
  logic [ADDR_W-WADDR_LSB-1:0] r_addr;
  logic [3:0]                  r_wmask;
  logic [31:0]                 r_wdata;
  logic [31:0]                 r_dfm;
  logic                        r_dvalid;
  logic                        r_err;

  logic w_idle, w_req, w_rwait, w_busy;
  logic w_nop, w_accept, w_conflict;
  logic w_rd_cap, w_tc, w_cnt_clr;
  logic w_unused_addr_lsb;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_req   = (r_state == ST_REQ);
  assign w_rwait = (r_state == ST_RWAIT);
  assign w_busy  = w_req | w_rwait;

  // A store with no enabled lanes needs no memory access at all
  assign w_nop      = MemWEn && (MemWriteMask == MASK_NONE);
  assign w_accept   = w_idle && (MemRen || MemWEn) && !w_nop;
  assign w_conflict = w_idle && MemRen && MemWEn;

  // Read data lands either in RWAIT or together with ready (zero-latency memory)
  assign w_rd_cap = (w_req && mem_ready && !r_we && mem_rvalid) || (w_rwait && mem_rvalid);

  // Counter restarts on entering REQ and again on entering RWAIT
  assign w_cnt_clr = w_accept || (w_req && mem_ready);

  assign w_unused_addr_lsb = ^MemAddress[WADDR_LSB-1:0];

  dmem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tcnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cnt_clr),
    .i_inc (w_busy),
    .o_tc  (w_tc)
  );

  assign Stall       = !rst && (w_accept || w_busy);
  assign mem_req     = w_req;
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wmask   = r_wmask;
  assign mem_wdata   = r_wdata;
  assign DataFromMem = r_dfm;
  assign DataValid   = r_dvalid;
  assign AccessErr   = r_err;

  // FSM, request field capture, read data capture and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wmask  <= MASK_NONE;
      r_wdata  <= '0;
      r_dfm    <= '0;
      r_dvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_dvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_conflict) r_err <= 1'b1;
          if (w_accept) begin
            // Write wins when both enables are set
            r_we    <= MemWEn;
            r_addr  <= MemAddress[ADDR_W-1:WADDR_LSB];
            r_wmask <= MemWEn ? MemWriteMask : MASK_NONE;
            r_wdata <= DataToMem;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            r_state <= (r_we || mem_rvalid) ? ST_DONE : ST_RWAIT;
            if (w_rd_cap) begin
              r_dfm    <= mem_rdata;
              r_dvalid <= 1'b1;
            end
          end else if (w_tc) begin
            r_err   <= 1'b1;
            r_dfm   <= '0;
            r_state <= ST_DONE;
          end
        end
        ST_RWAIT: begin
          if (w_rd_cap) begin
            r_dfm    <= mem_rdata;
            r_dvalid <= 1'b1;
            r_state  <= ST_DONE;
          end else if (w_tc) begin
            r_err   <= 1'b1;
            r_dfm   <= '0;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: random loads/stores against a
// responder with chosen ready/rvalid delays; expectations are derived from
// the transaction rules and checked by an independent monitor.
module tb_dmem_access_ctrl;

  localparam int AW = 10;
  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRen, MemWEn;
  logic [AW-1:0] MemAddress;
  logic [3:0]  MemWriteMask;
  logic [31:0] DataToMem;
  logic        Stall, DataValid, AccessErr;
  logic [31:0] DataFromMem;
  logic        mem_req, mem_we;
  logic [AW-3:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .MemRen(MemRen), .MemWEn(MemWEn),
    .MemAddress(MemAddress), .MemWriteMask(MemWriteMask), .DataToMem(DataToMem),
    .Stall(Stall), .DataFromMem(DataFromMem), .DataValid(DataValid),
    .AccessErr(AccessErr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mreq_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  mreq_t       q_mem[$];
  logic [31:0] q_rd[$];
  logic        model_err;
  logic [31:0] model_dfm;

  // responder configuration for the transaction in flight
  bit          m_rd, m_zl;
  bit          m_off = 1'b1;
  int          m_k, m_v;
  logic [31:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_Stall"}, 32'(Stall), 0);
    chk({tag, "_mem_req"}, 32'(mem_req), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wmask"}, 32'(mem_wmask), 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_DataFromMem"}, DataFromMem, 0);
    chk({tag, "_DataValid"}, 32'(DataValid), 0);
    chk({tag, "_AccessErr"}, 32'(AccessErr), 0);
  endtask

  // Memory responder: ready after m_k waiting REQ cycles, rvalid after m_v
  // waiting cycles (or together with ready when m_zl); stray rvalid elsewhere.
  initial begin
    int  rcnt = 0;
    int  wcnt = 0;
    bit  ph   = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk); #1;
      if (!m_off) begin
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        if (mem_req) begin
          if (rcnt == m_k) begin
            mem_ready = 1'b1;
            if (m_rd && m_zl) begin mem_rvalid = 1'b1; mem_rdata = m_data; end
            else if (m_rd) begin ph = 1'b1; wcnt = 0; end
          end else mem_rvalid = ($urandom_range(3) == 0);
          rcnt++;
        end else begin
          rcnt = 0;
          if (ph) begin
            if (!Stall) ph = 1'b0;
            else if (wcnt == m_v) begin mem_rvalid = 1'b1; mem_rdata = m_data; ph = 1'b0; end
            else wcnt++;
          end else mem_rvalid = ($urandom_range(3) == 0);
        end
      end else begin
        rcnt = 0; ph = 1'b0;
      end
    end
  end

  // Monitor: request fields on every REQ cycle, load data on every DataValid
  initial forever begin
    @(negedge clk); #2;
    if (!rst) begin
      if (mem_req) begin
        if (q_mem.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL mem_req_unexpected: got mem_req=1 expected no request");
        end else begin
          chk("mem_we", 32'(mem_we), 32'(q_mem[0].we));
          chk("mem_addr", 32'(mem_addr), 32'(q_mem[0].addr));
          chk("mem_wmask", 32'(mem_wmask), 32'(q_mem[0].wmask));
          if (q_mem[0].we) chk("mem_wdata", mem_wdata, q_mem[0].wdata);
          if (mem_ready) void'(q_mem.pop_front());
        end
      end
      if (DataValid) begin
        if (q_rd.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL dvalid_unexpected: got DataValid=1 data %h expected no pulse", DataFromMem);
        end else chk("load_data", DataFromMem, q_rd.pop_front());
      end
    end
  end

  // One pipeline request; called and returns aligned to a falling edge
  task automatic do_txn(input bit ren, input bit wen, input logic [AW-1:0] addr,
                        input logic [3:0] mask, input logic [31:0] data,
                        input int k, input int v, input bit zl, input logic [31:0] rdat);
    int    exp_stall, got_stall, guard;
    bit    nop, rd, tmo_req, tmo;
    mreq_t e;
    nop = wen && (mask == 4'h0);
    rd  = ren && !wen;
    tmo = 1'b0; tmo_req = 1'b0;
    if (ren && wen) model_err = 1'b1;
    if (nop || (!ren && !wen)) exp_stall = 0;
    else begin
      e.we = wen; e.addr = addr[AW-1:2]; e.wmask = wen ? mask : 4'h0; e.wdata = data;
      q_mem.push_back(e);
      if (k >= TO) begin exp_stall = 1 + TO; tmo = 1'b1; tmo_req = 1'b1; end
      else if (!rd || zl) exp_stall = 2 + k;
      else if (v >= TO) begin exp_stall = 2 + k + TO; tmo = 1'b1; end
      else exp_stall = 3 + k + v;
      if (tmo) begin model_err = 1'b1; model_dfm = '0; end
      else if (rd) begin model_dfm = rdat; q_rd.push_back(rdat); end
    end
    m_rd = rd; m_zl = zl; m_k = k; m_v = v; m_data = rdat;
    MemRen = ren; MemWEn = wen; MemAddress = addr; MemWriteMask = mask; DataToMem = data;
    #3 got_stall = int'(Stall);
    @(posedge clk); #1;
    MemRen = 1'b0; MemWEn = 1'b0;
    MemAddress = AW'($urandom); MemWriteMask = 4'($urandom); DataToMem = $urandom;
    guard = 0;
    forever begin
      @(negedge clk); #3;
      if (!Stall) break;
      got_stall++; guard++;
      if (guard > 60) begin
        n_tests++; n_fail++;
        $display("FAIL stall_bound: got Stall still high after %0d cycles expected release", guard);
        break;
      end
    end
    chk("stall_cycles", 32'(got_stall), 32'(exp_stall));
    @(negedge clk); #3;
    chk("AccessErr", 32'(AccessErr), 32'(model_err));
    chk("DataFromMem_hold", DataFromMem, model_dfm);
    if (tmo_req) void'(q_mem.pop_back());
    repeat ($urandom_range(2)) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic rand_txn(input bit allow_to);
    int kind;
    kind = $urandom_range(99);
    do_txn(kind < 50, kind >= 50, AW'($urandom),
           (kind >= 92) ? 4'h0 : 4'($urandom_range(15, 1)), $urandom,
           allow_to ? $urandom_range(TO + 1) : $urandom_range(TO - 1),
           allow_to ? $urandom_range(TO + 1) : $urandom_range(TO - 1),
           $urandom_range(3) == 0, $urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; m_off = 1'b1;
    MemRen = 1'b0; MemWEn = 1'b0; MemAddress = '0; MemWriteMask = '0; DataToMem = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; m_off = 1'b0;
    model_err = 1'b0; model_dfm = '0;
    q_mem.delete(); q_rd.delete();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    mreq_t e;
    rst = 1'b1;
    MemRen = 1'b0; MemWEn = 1'b0; MemAddress = '0; MemWriteMask = '0; DataToMem = '0;
    model_err = 1'b0; model_dfm = '0;
    @(negedge clk); #3;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0; m_off = 1'b0;
    @(negedge clk);

    // random traffic, memory always answers in time
    repeat (80) rand_txn(1'b0);

    // directed cases
    do_txn(1'b0, 1'b1, 10'h104, 4'hF, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0);
    do_txn(1'b1, 1'b0, 10'h008, 4'h0, 32'h0, 0, 2, 1'b0, 32'h12345678);
    do_txn(1'b0, 1'b1, 10'h010, 4'h0, 32'h11111111, 0, 0, 1'b0, 32'h0);
    do_txn(1'b0, 1'b1, 10'h222, 4'h4, 32'h00AB0000, 5, 0, 1'b0, 32'h0);
    do_txn(1'b1, 1'b0, 10'h3FF, 4'h0, 32'h0, 1, 0, 1'b1, 32'hA5A5C3C3);
    do_txn(1'b1, 1'b0, 10'h0F0, 4'h0, 32'h0, 0, TO - 1, 1'b0, 32'h0BADCAFE);
    do_txn(1'b1, 1'b0, 10'h00C, 4'h0, 32'h0, TO, 0, 1'b0, 32'hFFFFFFFF);
    do_txn(1'b1, 1'b0, 10'h2A8, 4'h0, 32'h0, 2, TO, 1'b0, 32'h13572468);
    do_reset();

    // random traffic including timeouts
    repeat (80) rand_txn(1'b1);
    do_reset();

    // both enables: write wins, error flagged
    do_txn(1'b1, 1'b1, 10'h1C4, 4'h3, 32'h0000BEEF, 1, 0, 1'b0, 32'h0);
    do_reset();
    do_txn(1'b1, 1'b1, 10'h1C8, 4'h0, 32'h0000BEEF, 0, 0, 1'b0, 32'h0);
    do_reset();

    // reset while waiting for read data
    m_rd = 1'b1; m_zl = 1'b0; m_k = 0; m_v = 20; m_data = 32'hCAFEF00D;
    e.we = 1'b0; e.addr = 8'hFF; e.wmask = 4'h0; e.wdata = 32'h0;
    q_mem.push_back(e);
    MemRen = 1'b1; MemAddress = 10'h3FC;
    @(posedge clk); #1 MemRen = 1'b0;
    @(negedge clk);
    @(negedge clk); #3;
    chk("rwait_stall", 32'(Stall), 1);
    rst = 1'b1; m_off = 1'b1;
    #1 chk_zero("midread_reset");
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; mem_ready = 1'b0;
    repeat (3) begin
      @(negedge clk); #3;
      chk("post_reset_DataValid", 32'(DataValid), 0);
      chk("post_reset_DataFromMem", DataFromMem, 0);
      chk("post_reset_Stall", 32'(Stall), 0);
    end
    mem_rvalid = 1'b0;

    chk("q_mem_left", 32'(q_mem.size()), 0);
    chk("q_rd_left", 32'(q_rd.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sits directly downstream of partial_store in the MEM stage. Consumes MemWriteMask, DataToMem and MemAddress, plus a load request.
- Runs a request/ready/rvalid handshake to the data memory and holds the pipeline (Stall) until each access completes.
- Returns the raw 32-bit load word to the partial-load/extension logic.
- Bounds every access with a timeout and reports a sticky error.

Parameters:
- ADDR_W, 10, width of the byte address from the pipeline
- TIMEOUT, 255, maximum cycles waiting on mem_ready or mem_rvalid before abort (1..65535)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- MemRen  in  1  load request from MEM stage
- MemWEn  in  1  store request from MEM stage
- MemAddress  in  ADDR_W  byte address
- MemWriteMask  in  4  byte-lane write enables from partial_store
- DataToMem  in  32  lane-aligned store data from partial_store
- Stall  out  1  holds pipeline while an access is in flight
- DataFromMem  out  32  load word, valid when DataValid=1
- DataValid  out  1  one-cycle pulse when load data is returned
- AccessErr  out  1  sticky timeout/illegal-request flag
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W-2  word address (MemAddress[ADDR_W-1:2])
- mem_wmask  out  4  byte enables (0 on reads)
- mem_wdata  out  32  write data
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data

Behaviour:
- Reset (async, rst=1): state IDLE. Stall=0, DataValid=0, DataFromMem=0, AccessErr=0, mem_req=0, mem_we=0, mem_addr=0, mem_wmask=0, mem_wdata=0, timeout counter=0. Reset mid-transaction aborts it immediately and drops mem_req the same instant.
- FSM states: IDLE, REQ, RWAIT, DONE.
- IDLE:
  - Accept when MemRen|MemWEn.
  - Latch address, mask, data and direction into registers.
  - Go to REQ. Stall is combinationally 1 in the accept cycle.
  - MemWEn with MemWriteMask==0: no memory transaction, no stall, stay IDLE.
  - MemRen&MemWEn: write wins; set AccessErr.
- REQ:
  - mem_req=1 with the registered fields; fields are stable until mem_ready.
  - On mem_ready: write goes to DONE; read goes to RWAIT.
  - Stall=1.
- RWAIT:
  - mem_req=0. On mem_rvalid, capture mem_rdata into DataFromMem and go to DONE.
  - mem_rvalid in the same cycle as mem_ready (zero-latency memory): REQ goes straight to DONE, data captured. mem_rvalid outside RWAIT and that REQ case is ignored.
  - Stall=1.
- DONE:
  - Stall=0 for one cycle. DataValid=1 for completed reads.
  - Always return to IDLE; no new request is accepted in the DONE cycle. The pipeline advances in this cycle, so the next request is seen in the following IDLE.
- Latency:
  - Store: 2 cycles of Stall minimum (accept, REQ with ready).
  - Load: accept + REQ + rvalid wait, then DONE.
- Timeout:
  - Counter clears on entering REQ/RWAIT and increments each cycle in REQ/RWAIT.
  - Reaching TIMEOUT sets AccessErr, drops mem_req, sets DataFromMem=0, goes to DONE with DataValid=0.
  - AccessErr clears only on rst.
- DataFromMem holds its last value until the next captured read or timeout.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, REQ=1, RWAIT=2, DONE=3)
  - word-address slicing constant (2 low bits dropped)
  - mask constant MASK_NONE=4'b0000
- One natural sub-module: dmem_timeout_cnt (load/clear/increment counter with a terminal-count flag, width from TIMEOUT).

Test Plan:
- Store word: MemWEn=1, MemAddress=10'h104, mask=4'hF, data=32'hDEADBEEF, mem_ready=1 in the first REQ cycle -> mem_addr=8'h41, mem_wmask=F, mem_we=1, Stall high 2 cycles, no DataValid.
- Load with 3-cycle rvalid delay: MemRen=1, addr=10'h008, mem_rdata=32'h12345678 -> Stall until DONE, DataFromMem=12345678, DataValid pulse of exactly 1 cycle, mem_wmask=0.
- Zero-mask store: MemWEn=1, mask=0 -> mem_req never asserts, Stall stays 0.
- Timeout: TIMEOUT=4, load with mem_ready held 0 -> after 4 REQ cycles AccessErr=1, mem_req=0, DataFromMem=0, DataValid=0, return to IDLE.
- Backpressure: byte store mask=4'h4, data=32'h00AB0000, mem_ready low 5 cycles -> mem_addr/mem_wmask/mem_wdata constant throughout, completes on ready.
- Reset mid-read: assert rst while in RWAIT -> all outputs zero immediately; a later mem_rvalid produces no DataValid.
